// File: rtl/ram_arbiter_2m.sv
// rtl/ram_arbiter_2m.sv - two-master round-robin arbiter in front of a single-port on-chip RAM
module ram_arbiter_2m #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int BE_W     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  logic       prio;
  logic       owner;
  logic [3:0] hold_cnt;
  logic       rd_pend;
  logic       rd_who;

  logic req0, req1;
  logic gnt_valid, gnt_who;
  logic gnt_write, gnt_read;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant is suppressed during reset so no access leaks out while state is cleared.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_who   = 1'b0;
    if (!reset) begin
      if (req0 && !req1) begin
        gnt_valid = 1'b1;
        gnt_who   = 1'b0;
      end else if (req1 && !req0) begin
        gnt_valid = 1'b1;
        gnt_who   = 1'b1;
      end else if (req0 && req1) begin
        gnt_valid = 1'b1;
        gnt_who   = (hold_cnt < HOLD_LIM) ? owner : prio;
      end
    end
  end

  assign gnt_write = gnt_who ? m1_write : m0_write;
  assign gnt_read  = gnt_who ? (m1_read & ~m1_write) : (m0_read & ~m0_write);

  assign m0_waitrequest = reset | (req0 & ~(gnt_valid & ~gnt_who));
  assign m1_waitrequest = reset | (req1 & ~(gnt_valid &  gnt_who));

  // With no grant the mux rests on master 0.
  assign ram_address    = (gnt_valid && gnt_who) ? m1_address    : m0_address;
  assign ram_byteenable = (gnt_valid && gnt_who) ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = (gnt_valid && gnt_who) ? m1_writedata  : m0_writedata;
  assign ram_chipselect = gnt_valid;
  assign ram_write      = gnt_valid & gnt_write;
  assign ram_clken      = ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio     <= 1'b0;
      owner    <= 1'b0;
      hold_cnt <= 4'd0;
    end else if (gnt_valid) begin
      owner    <= gnt_who;
      prio     <= ~gnt_who;
      if (gnt_who == owner)
        hold_cnt <= (hold_cnt == 4'd15) ? 4'd15 : hold_cnt + 4'd1;
      else
        hold_cnt <= 4'd1;
    end else begin
      hold_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_who  <= 1'b0;
    end else begin
      rd_pend <= gnt_valid & gnt_read;
      if (gnt_valid)
        rd_who <= gnt_who;
    end
  end

  assign m0_readdatavalid = rd_pend & ~rd_who;
  assign m1_readdatavalid = rd_pend &  rd_who;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_ram_arbiter_2m.sv
// tb/tb_ram_arbiter_2m.sv - randomized and directed bench for ram_arbiter_2m
module tb_ram_arbiter_2m;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rd [2];
  logic        wr [2];
  logic [13:0] ad [2];
  logic [31:0] wd [2];
  logic [3:0]  be [2];

  logic        m0_waitrequest, m1_waitrequest;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [13:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;

  ram_arbiter_2m #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (ad[0]),
    .m0_read          (rd[0]),
    .m0_write         (wr[0]),
    .m0_writedata     (wd[0]),
    .m0_byteenable    (be[0]),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (ad[1]),
    .m1_read          (rd[1]),
    .m1_write         (wr[1]),
    .m1_writedata     (wd[1]),
    .m1_byteenable    (be[1]),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata)
  );

  // RAM slave: registered address, unregistered output, byte-enabled writes.
  logic [31:0] ram_mem [0:16383];
  logic [13:0] addr_q;
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16384; i++) ram_mem[i] <= '0;
      addr_q <= '0;
    end else if (ram_clken) begin
      addr_q <= ram_address;
      if (ram_chipselect && ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    end
  end
  assign ram_readdata = ram_mem[addr_q];

  // Reference state: expected memory, grant history (-1 = idle cycle), pending read.
  logic [31:0] exp_mem [0:16383];
  int          hist [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int model_winner();
    logic r0, r1;
    int last, owner, prio, streak;
    r0 = rd[0] | wr[0];
    r1 = rd[1] | wr[1];
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    last = -1;
    for (int i = hist.size() - 1; i >= 0; i--)
      if (hist[i] >= 0) begin last = hist[i]; break; end
    owner  = (last < 0) ? 0 : last;
    prio   = (last < 0) ? 0 : 1 - last;
    streak = 0;
    for (int i = hist.size() - 1; i >= 0 && streak < 16; i--)
      if (hist[i] == owner && last >= 0) streak++;
      else break;
    return (streak < MAX_HOLD) ? owner : prio;
  endfunction

  task automatic do_cycle(output int win);
    int          w, s;
    logic        pv;
    int          pwho;
    logic [31:0] pdata;
    #1;
    w = model_winner();
    s = (w == 1) ? 1 : 0;
    chk("m0_wait", m0_waitrequest, (rd[0] | wr[0]) && w != 0);
    chk("m1_wait", m1_waitrequest, (rd[1] | wr[1]) && w != 1);
    chk("ram_cs", ram_chipselect, w >= 0);
    chk("ram_write", ram_write, w >= 0 && wr[s]);
    chk("ram_addr", ram_address, ad[s]);
    chk("ram_be", ram_byteenable, be[s]);
    chk("ram_wdata", ram_writedata, wd[s]);
    chk("ram_clken", ram_clken, 1);
    pv = 1'b0; pwho = 0; pdata = '0;
    if (w >= 0) begin
      if (wr[s]) begin
        for (int b = 0; b < 4; b++)
          if (be[s][b]) exp_mem[ad[s]][8*b +: 8] = wd[s][8*b +: 8];
      end else begin
        pv = 1'b1; pwho = w; pdata = exp_mem[ad[s]];
      end
    end
    hist.push_back(w);
    @(posedge clk); #1;
    chk("m0_rdv", m0_readdatavalid, pv && pwho == 0);
    chk("m1_rdv", m1_readdatavalid, pv && pwho == 1);
    if (pv) chk("rdata", (pwho == 1) ? m1_readdata : m0_readdata, pdata);
    win = w;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0; wr[i] = 0; ad[i] = '0; wd[i] = '0; be[i] = 4'hF;
    end
  endtask

  initial begin
    int w, waits;
    idle_all();
    for (int i = 0; i < 16384; i++) exp_mem[i] = '0;
    mem_clr = 1'b1;
    reset   = 1'b1;
    rd[0] = 1; rd[1] = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    chk("rst_clken", ram_clken, 0);
    mem_clr = 1'b0;
    idle_all();
    @(posedge clk); #1;
    reset = 1'b0;

    // Write then read back through master 0.
    wr[0] = 1; ad[0] = 14'h0010; wd[0] = 32'hDEADBEEF; be[0] = 4'hF;
    do_cycle(w); chk("t1_wr_grant", w, 0);
    idle_all(); rd[0] = 1; ad[0] = 14'h0010;
    do_cycle(w); chk("t1_rd_grant", w, 0);
    chk("t1_rdata", m0_readdata, 32'hDEADBEEF);
    idle_all();
    do_cycle(w);

    // m0 streams writes, m1 joins on m0's 2nd grant: m0 keeps 4 grants in a row.
    wr[0] = 1; ad[0] = 14'h0040; wd[0] = 32'h0000_0100;
    do_cycle(w); chk("hold_g1", w, 0);
    rd[1] = 1; ad[1] = 14'h0040;
    waits = 0;
    for (int k = 2; k <= 5; k++) begin
      ad[0] = ad[0] + 14'd1; wd[0] = wd[0] + 32'd1;
      do_cycle(w);
      chk("hold_seq", w, (k < 5) ? 0 : 1);
      if (w == 0) waits++;
    end
    chk("hold_m1_waits", waits, 3);
    idle_all();
    do_cycle(w);

    // Byte-enabled merge at the top address.
    wr[0] = 1; ad[0] = 14'h3FFF; wd[0] = 32'hFFFFFFFF; be[0] = 4'hF;
    do_cycle(w);
    idle_all(); wr[1] = 1; ad[1] = 14'h3FFF; wd[1] = 32'h11223344; be[1] = 4'b0101;
    do_cycle(w); chk("be_wr_grant", w, 1);
    idle_all(); rd[0] = 1; ad[0] = 14'h3FFF;
    do_cycle(w);
    chk("be_rdata", m0_readdata, 32'hFF22FF44);

    // Read and write together behaves as a write only.
    idle_all(); rd[0] = 1; wr[0] = 1; ad[0] = 14'h0020; wd[0] = 32'h5;
    do_cycle(w);
    chk("rw_no_rdv", m0_readdatavalid, 0);
    idle_all(); rd[0] = 1; ad[0] = 14'h0020;
    do_cycle(w);
    chk("rw_rdata", m0_readdata, 32'h5);

    // Reset right after a granted m1 read.
    idle_all(); rd[1] = 1; ad[1] = 14'h0002;
    #1 chk("rst2_pre_grant", m1_waitrequest, 0);
    @(posedge clk);
    reset = 1'b1; rd[0] = 1; ad[0] = 14'h0001;
    #1;
    chk("rst2_m1_rdv", m1_readdatavalid, 0);
    chk("rst2_m0_rdv", m0_readdatavalid, 0);
    chk("rst2_m0_wait", m0_waitrequest, 1);
    chk("rst2_m1_wait", m1_waitrequest, 1);
    chk("rst2_cs", ram_chipselect, 0);
    chk("rst2_wr", ram_write, 0);
    @(negedge clk);
    chk("rst2_m1_rdv_late", m1_readdatavalid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    hist.delete();
    do_cycle(w); chk("rst2_tie", w, 0);

    // Randomized traffic; requests stay stable until accepted.
    idle_all();
    do_cycle(w);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (w == i || !(rd[i] | wr[i])) begin
          int op;
          op = $urandom_range(0, 9);
          rd[i] = (op >= 3 && op <= 5) || op == 9;
          wr[i] = (op >= 6);
          ad[i] = ($urandom_range(0, 15) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
          wd[i] = $urandom;
          be[i] = 4'($urandom_range(0, 15));
        end
      end
      do_cycle(w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
